// File: rtl/frank_alu.sv
// frank_alu: 8-bit accumulator-style ALU for the FRANK6000 datapath.
// Combines WREG with operand p under a 4-bit opcode; the result and the
// Z/N/C status flags are computed combinationally and registered once.
module frank_alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [7:0] WREG,
  input  logic [7:0] p,
  output logic [7:0] res,
  output logic [2:0] status
);

  typedef enum logic [3:0] {
    OP_ZEROW = 4'd0,
    OP_BNOTW = 4'd1,
    OP_NEGTW = 4'd2,
    OP_INCRW = 4'd3,
    OP_DECRW = 4'd4,
    OP_ANDWP = 4'd5,
    OP_IORWP = 4'd6,
    OP_XORWP = 4'd7,
    OP_ADDWP = 4'd8,
    OP_SUBWP = 4'd9,
    OP_CMPWP = 4'd10,
    OP_SHFLW = 4'd11,
    OP_SHFRW = 4'd12
  } op_t;

  op_t        op;
  logic [8:0] sum_wide;
  logic [8:0] diff_wide;
  logic       shift_too_far;
  logic [7:0] result_next;
  logic       carry_next;
  logic [2:0] status_next;

  assign op            = op_t'(opcode);
  assign sum_wide      = {1'b0, WREG} + {1'b0, p};
  assign diff_wide     = {1'b0, WREG} - {1'b0, p};
  assign shift_too_far = (p >= 8'd8);

  // Select the result for the current opcode; only ADD/SUB produce a carry.
  always_comb begin
    result_next = 8'h00;
    carry_next  = 1'b0;
    case (op)
      OP_ZEROW: result_next = 8'h00;
      OP_BNOTW: result_next = ~WREG;
      OP_NEGTW: result_next = 8'h00 - WREG;
      OP_INCRW: result_next = WREG + 8'h01;
      OP_DECRW: result_next = WREG - 8'h01;
      OP_ANDWP: result_next = WREG & p;
      OP_IORWP: result_next = WREG | p;
      OP_XORWP: result_next = WREG ^ p;
      OP_ADDWP: begin
        result_next = sum_wide[7:0];
        carry_next  = sum_wide[8];
      end
      OP_SUBWP: begin
        result_next = diff_wide[7:0];
        carry_next  = diff_wide[8];
      end
      OP_CMPWP: begin
        if ($signed(WREG) > $signed(p)) begin
          result_next = 8'h01;
        end else if ($signed(WREG) < $signed(p)) begin
          result_next = 8'hFF;
        end else begin
          result_next = 8'h00;
        end
      end
      OP_SHFLW: result_next = shift_too_far ? 8'h00 : (WREG << p[2:0]);
      OP_SHFRW: result_next = shift_too_far ? 8'h00 : (WREG >> p[2:0]);
      default:  result_next = 8'h00;
    endcase
  end

  // Pack the flags: [0] zero, [1] negative, [2] carry/borrow.
  always_comb begin
    status_next    = 3'b000;
    status_next[0] = (result_next == 8'h00);
    status_next[1] = result_next[7];
    status_next[2] = carry_next;
  end

  // Output register; reset clears immediately and drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= 8'h00;
      status <= 3'b000;
    end else begin
      res    <= result_next;
      status <= status_next;
    end
  end

endmodule

// File: tb/tb_frank_alu.sv
// tb_frank_alu: directed and randomized checks of frank_alu against a
// plain-arithmetic reference model of the opcode rules.
module tb_frank_alu;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] WREG;
  logic [7:0] p;
  logic [7:0] res;
  logic [2:0] status;

  int checks   = 0;
  int failures = 0;

  frank_alu dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .WREG   (WREG),
    .p      (p),
    .res    (res),
    .status (status)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {status, result} from integer arithmetic.
  function automatic logic [10:0] refModel(input int op, input int w, input int q);
    int r;
    int c;
    int sw;
    int sq;
    logic [7:0] r8;
    logic [2:0] st;
    r = 0;
    c = 0;
    sw = (w > 127) ? w - 256 : w;
    sq = (q > 127) ? q - 256 : q;
    case (op)
      0:  r = 0;
      1:  r = 255 - w;
      2:  r = (256 - w) % 256;
      3:  r = (w + 1) % 256;
      4:  r = (w + 255) % 256;
      5:  r = w & q;
      6:  r = w | q;
      7:  r = w ^ q;
      8:  begin r = (w + q) % 256; c = (w + q > 255) ? 1 : 0; end
      9:  begin r = (w - q + 256) % 256; c = (w < q) ? 1 : 0; end
      10: r = (sw > sq) ? 1 : ((sw < sq) ? 255 : 0);
      11: r = (q >= 8) ? 0 : ((w * (1 << q)) % 256);
      12: r = (q >= 8) ? 0 : (w / (1 << q));
      default: r = 0;
    endcase
    r8 = r[7:0];
    st[0] = (r == 0);
    st[1] = (r >= 128);
    st[2] = (c != 0);
    return {st, r8};
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] w, input logic [7:0] q);
    opcode = op;
    WREG   = w;
    p      = q;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_res, input logic [2:0] exp_st);
    checks++;
    assert ({status, res} === {exp_st, exp_res})
    else begin
      failures++;
      $error("[TB] FAIL %s res=%h status=%b expected res=%h status=%b",
             tag, res, status, exp_res, exp_st);
    end
  endtask

  // Apply one vector, clock it in, then check #1 after the edge.
  task automatic stepDirected(input string tag, input logic [3:0] op, input logic [7:0] w,
                              input logic [7:0] q, input logic [7:0] exp_res,
                              input logic [2:0] exp_st);
    applyStimulus(op, w, q);
    @(posedge clk);
    #1;
    checkOutput(tag, exp_res, exp_st);
  endtask

  logic [10:0] expv;
  logic [3:0]  rop;
  logic [7:0]  rw;
  logic [7:0]  rp;

  initial begin
    rst = 1'b1;
    applyStimulus(4'd0, 8'h00, 8'h00);
    #2;
    checkOutput("reset_initial", 8'h00, 3'b000);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Load a nonzero result, then reset asynchronously mid-cycle.
    stepDirected("preload_bnot", 4'd1, 8'h00, 8'h00, 8'hFF, 3'b010);
    applyStimulus(4'd8, 8'd200, 8'd100);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 8'h00, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_edge", 8'h00, 3'b000);
    #2;
    rst = 1'b0;

    stepDirected("zero_after_rst", 4'd0, 8'hFF, 8'h00, 8'h00, 3'b001);

    stepDirected("bnot_55",   4'd1, 8'h55, 8'h00, 8'hAA, 3'b010);
    stepDirected("negt_0a",   4'd2, 8'h0A, 8'h00, 8'hF6, 3'b010);
    stepDirected("negt_80",   4'd2, 8'h80, 8'h00, 8'h80, 3'b010);
    stepDirected("incr_ff",   4'd3, 8'hFF, 8'h00, 8'h00, 3'b001);
    stepDirected("decr_80",   4'd4, 8'h80, 8'h00, 8'h7F, 3'b000);
    stepDirected("decr_00",   4'd4, 8'h00, 8'h00, 8'hFF, 3'b010);
    stepDirected("and_cc_aa", 4'd5, 8'hCC, 8'hAA, 8'h88, 3'b010);
    stepDirected("or_cc_aa",  4'd6, 8'hCC, 8'hAA, 8'hEE, 3'b010);
    stepDirected("xor_cc_aa", 4'd7, 8'hCC, 8'hAA, 8'h66, 3'b000);
    stepDirected("add_carry", 4'd8, 8'd200, 8'd100, 8'h2C, 3'b100);
    stepDirected("add_neg",   4'd8, 8'd90, 8'd80, 8'hAA, 3'b010);
    stepDirected("sub_pos",   4'd9, 8'd75, 8'd50, 8'h19, 3'b000);
    stepDirected("sub_brw",   4'd9, 8'd75, 8'hCE, 8'h7D, 3'b100);
    stepDirected("sub_brw_n", 4'd9, 8'hB5, 8'hCE, 8'hE7, 3'b110);
    stepDirected("sub_equal", 4'd9, 8'h42, 8'h42, 8'h00, 3'b001);
    stepDirected("cmp_gt",    4'd10, 8'd80, 8'd70, 8'h01, 3'b000);
    stepDirected("cmp_lt",    4'd10, 8'd80, 8'd90, 8'hFF, 3'b010);
    stepDirected("cmp_eq",    4'd10, 8'd80, 8'd80, 8'h00, 3'b001);
    stepDirected("cmp_signed",4'd10, 8'h80, 8'h01, 8'hFF, 3'b010);
    stepDirected("shfl_3",    4'd11, 8'hCC, 8'd3, 8'h60, 3'b000);
    stepDirected("shfl_8",    4'd11, 8'hFF, 8'd8, 8'h00, 3'b001);
    stepDirected("shfr_3",    4'd12, 8'hCC, 8'd3, 8'h19, 3'b000);
    stepDirected("shfr_7",    4'd12, 8'h80, 8'd7, 8'h01, 3'b000);
    stepDirected("shfr_9",    4'd12, 8'hCC, 8'd9, 8'h00, 3'b001);
    stepDirected("op13",      4'd13, 8'hFF, 8'hFF, 8'h00, 3'b001);

    // Back-to-back random vectors: every output reflects the prior vector.
    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(0, 12));
      rw  = 8'($urandom);
      rp  = (rop >= 4'd11) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      expv = refModel(int'(rop), int'(rw), int'(rp));
      stepDirected($sformatf("pipe_%0d", i), rop, rw, rp, expv[7:0], expv[10:8]);
    end
    stepDirected("pipe_op14", 4'd14, 8'h5A, 8'hA5, 8'h00, 3'b001);

    // Wider random sweep across all opcodes including the unused ones.
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      rw  = 8'($urandom);
      rp  = (rop >= 4'd11 && rop <= 4'd12) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      expv = refModel(int'(rop), int'(rw), int'(rp));
      stepDirected($sformatf("rand_%0d_op%0d", i, rop), rop, rw, rp, expv[7:0], expv[10:8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
